topk_select: RTL and testbench
==============================

// Module: topk_select
// PURPOSE
//  Streaming top-K selector, successor to the pipelined heap: keeps the DEPTH best keys of a stream
//  in a sorted register array with one insertion per cycle, valid/ready on both sides, runtime
//  K, compile-time min/max mode and a counted drain. Sits after feature scoring, before descriptor fetch.
// PARAMETERS
//  DATA_WIDTH  32  word width; key is word[KEY_WIDTH-1:0], rest is payload carried unchanged
//  KEY_WIDTH   16  unsigned compare key width
//  DEPTH       16  max retained entries (K), >=2
//  MAX_MODE    0   0: keep smallest keys, drain ascending; 1: keep largest, drain descending
//  CNT_W       $clog2(DEPTH+1)  occupancy/K width (localparam)
// PORTS
//  clk        in   1           clock
//  rstn       in   1           asynchronous active-low reset
//  init       in   1           sync clear of array, counters, FSM; samples k_cfg
//  k_cfg      in   CNT_W       active K; 0 or >DEPTH means DEPTH
//  in_data    in   DATA_WIDTH  candidate word
//  in_valid   in   1           candidate present
//  in_ready   out  1           1 in ACCEPT state only
//  flush      in   1           pulse: begin drain after this cycle's insertion
//  out_data   out  DATA_WIDTH  drained word, best first
//  out_valid  out  1           drain word present
//  out_ready  in   1           consumer accepts
//  out_last   out  1           with out_valid: final word of drain
//  evict_valid out 1           1-cycle pulse: a word was discarded (new or displaced worst)
//  count      out  CNT_W       entries held, saturates at active K
//  done       out  1           1-cycle pulse when drain completes (incl. empty drain)
// BEHAVIOUR
//  - Reset/init: all outputs 0 except in_ready=1 after reset; array entries invalid; k_act=DEPTH
//    on reset, k_cfg-derived on init. init overrides every other input same cycle.
//  - "Better": MAX_MODE=0 a<b, MAX_MODE=1 a>b, unsigned key. Equal keys: new word goes after
//    existing equals (stable, arrival order among ties).
//  - FSM ACCEPT: in_valid&in_ready inserts; all DEPTH slots compared in parallel, new word lands
//    at first slot it beats (or first invalid slot), lower slots shift down one. Visible next cycle.
//    count<k_act: count+1. count==k_act: slot k_act-1 drops; if new word not better than it,
//    new word itself dropped; either way evict_valid=1 next cycle, count unchanged.
//    Slots >= k_act never hold valid data.
//  - flush sampled in ACCEPT (in_valid same cycle is inserted first, included in drain):
//    count==0 -> done=1 next cycle, stay ACCEPT; else -> DRAIN, in_ready=0 next cycle.
//    flush in DRAIN ignored.
//  - DRAIN: out_data=slot0 registered, out_valid=1 from first DRAIN cycle; on out_valid&out_ready
//    array shifts up one, count-1; out_last=1 when count==1. Handshake on last word ->
//    array empty, done=1 and in_ready=1 next cycle, state ACCEPT. out_data stable while
//    out_valid&!out_ready.
//  - init mid-drain aborts: out_valid=0, count=0 next cycle, no done pulse.
//  - Throughput: 1 insert/cycle, 1 drain word/cycle; drain of N words takes N cycles at full ready.
// STRUCTURE
//  - Shared package heap_pkg: cmp_better(a,b,max_mode) function, KEY slice helpers, FSM state
//    enum (ACCEPT, DRAIN), shared with heap/sort_node.
//  - Sub-module topk_cell: one slot (data+valid regs, comparator vs. in_data, shift-in mux
//    from upper/lower neighbour); top level instantiates DEPTH cells in a generate loop
//    and holds FSM, counters, k_act register and output register.
// TESTING
//  - DEPTH=4,MAX=0,K=4: insert 9,3,7,1,8,2, flush -> out 1,2,3,7, last on 7, 2 evict pulses, done.
//  - MAX=1,k_cfg=3 via init: insert 5,12,12,4,20, flush -> 20,12(first),12(second); 2 evicts.
//  - Backpressure: 3 entries, out_ready toggles 1010.. -> each word held stable until accepted,
//    done 1 cycle after 3rd handshake, in_ready low throughout drain.
//  - flush with in_valid same cycle, array {2,6}, in 4 -> drain 2,4,6; flush on empty -> done only.
//  - init at 2nd drain word -> out_valid 0, count 0 next cycle, no done; new stream sorts cleanly.
//  - rstn asserted mid-insert stream -> all outputs 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/heap_pkg.sv
// heap_pkg: compare helpers and FSM state type shared by the top-K selector and the heap/sort cells.
package heap_pkg;
  typedef enum logic {ACCEPT, DRAIN} state_t;
  function automatic logic [63:0] key_of(input logic [63:0] w, input int unsigned kw);
    return w & ((64'd1 << kw) - 64'd1);
  endfunction
  // Strict comparison keeps equal keys in arrival order.
  function automatic logic cmp_better(input logic [63:0] a, input logic [63:0] b, input logic max_mode);
    return max_mode ? a > b : a < b;
  endfunction
endpackage

// File: rtl/topk_select_if.sv
// topk_select_if: valid/ready word stream with an end-of-burst marker.
interface topk_select_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  logic last;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/topk_cell.sv
// topk_cell: one sorted slot; takes the new word, its upper neighbour (insert shift) or lower neighbour (drain shift).
module topk_cell
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 16,
  parameter bit MAX_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  ins,
  input  logic                  shift,
  input  logic                  keep,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_valid,
  input  logic                  up_beat,
  input  logic [DATA_WIDTH-1:0] lo_data,
  input  logic                  lo_valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  beat
);
  assign beat = !valid || cmp_better(key_of(64'(in_data), KEY_WIDTH), key_of(64'(data), KEY_WIDTH), MAX_MODE);
  // beat is monotonic across the sorted array, so the insert point is where it first rises.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      data <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      data <= '0;
      valid <= 1'b0;
    end else if (ins && up_beat) begin
      data <= up_data;
      valid <= up_valid && keep;
    end else if (ins && beat) begin
      data <= in_data;
      valid <= keep;
    end else if (shift) begin
      data <= lo_data;
      valid <= lo_valid;
    end
endmodule

// File: rtl/topk_select.sv
// topk_select: streaming top-K selector over a sorted slot array with counted, best-first drain.
module topk_select
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter bit MAX_MODE = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             init,
  input  logic [CNT_W-1:0] k_cfg,
  input  logic             flush,
  topk_select_if.slave     in_s,
  topk_select_if.master    out_m,
  output logic             evict_valid,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  logic [DATA_WIDTH-1:0] dx [DEPTH+2];
  logic vx [DEPTH+2];
  logic bx [DEPTH+1];
  state_t state, state_nxt;
  logic [CNT_W-1:0] k_act, cnt_nxt;
  logic rdy, ov, ol, ins, pop, full;
  assign dx[0] = '0;
  assign vx[0] = 1'b0;
  assign bx[0] = 1'b0;
  assign dx[DEPTH+1] = '0;
  assign vx[DEPTH+1] = 1'b0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    topk_cell #(.DATA_WIDTH(DATA_WIDTH), .KEY_WIDTH(KEY_WIDTH), .MAX_MODE(MAX_MODE)) u_cell (
      .clk(clk), .rstn(rstn), .clr(init), .ins(ins), .shift(pop),
      .keep(i < int'(k_act)),
      .in_data(in_s.data),
      .up_data(dx[i]), .up_valid(vx[i]), .up_beat(bx[i]),
      .lo_data(dx[i+2]), .lo_valid(vx[i+2]),
      .data(dx[i+1]), .valid(vx[i+1]), .beat(bx[i+1])
    );
  end
  assign ins = state == ACCEPT && in_s.valid && rdy && !init;
  assign pop = state == DRAIN && ov && out_m.ready && !init;
  assign full = count == k_act;
  assign in_s.ready = rdy;
  assign out_m.valid = ov;
  assign out_m.last = ol;
  assign out_m.data = ov ? dx[1] : '0;
  always_comb begin
    cnt_nxt = count;
    state_nxt = state;
    if (ins && !full) cnt_nxt = count + CNT_W'(1);
    if (pop) cnt_nxt = count - CNT_W'(1);
    if (state == ACCEPT && flush && cnt_nxt != '0) state_nxt = DRAIN;
    if (pop && count == CNT_W'(1)) state_nxt = ACCEPT;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ACCEPT;
      count <= '0;
      k_act <= CNT_W'(DEPTH);
      rdy <= 1'b0;
      ov <= 1'b0;
      ol <= 1'b0;
      evict_valid <= 1'b0;
      done <= 1'b0;
    end else if (init) begin
      state <= ACCEPT;
      count <= '0;
      k_act <= (k_cfg == '0 || int'(k_cfg) > DEPTH) ? CNT_W'(DEPTH) : k_cfg;
      rdy <= 1'b1;
      ov <= 1'b0;
      ol <= 1'b0;
      evict_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
      rdy <= state_nxt == ACCEPT;
      ov <= state_nxt == DRAIN;
      ol <= state_nxt == DRAIN && cnt_nxt == CNT_W'(1);
      evict_valid <= ins && full;
      done <= (state == ACCEPT && flush && cnt_nxt == '0) || (pop && count == CNT_W'(1));
    end
endmodule

// File: tb/tb_topk_select.sv
// tb_topk_select: directed checks of a min-mode and a max-mode selector driven by the same stream.
module tb_topk_select;
  localparam int DW = 32;
  localparam int D = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic init = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] k_cfg = '0;
  logic ev_a, ev_b, dn_a, dn_b;
  logic [CW-1:0] cnt_a, cnt_b;
  int total = 0;
  int bad = 0;
  int ea = 0;
  int eb = 0;
  logic [31:0] exp_q[$];
  topk_select_if #(.DATA_WIDTH(DW)) a_in();
  topk_select_if #(.DATA_WIDTH(DW)) a_out();
  topk_select_if #(.DATA_WIDTH(DW)) b_in();
  topk_select_if #(.DATA_WIDTH(DW)) b_out();
  assign b_in.data = a_in.data;
  assign b_in.valid = a_in.valid;
  assign b_in.last = a_in.last;
  assign b_out.ready = a_out.ready;
  topk_select #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .DEPTH(D), .MAX_MODE(1'b0)) u_min (
    .clk(clk), .rstn(rstn), .init(init), .k_cfg(k_cfg), .flush(flush),
    .in_s(a_in), .out_m(a_out), .evict_valid(ev_a), .count(cnt_a), .done(dn_a)
  );
  topk_select #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .DEPTH(D), .MAX_MODE(1'b1)) u_max (
    .clk(clk), .rstn(rstn), .init(init), .k_cfg(k_cfg), .flush(flush),
    .in_s(b_in), .out_m(b_out), .evict_valid(ev_b), .count(cnt_b), .done(dn_b)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] w(input int p, input int k);
    return {p[15:0], k[15:0]};
  endfunction
  function automatic logic fv(input bit mx);
    return mx ? b_out.valid : a_out.valid;
  endfunction
  function automatic logic [31:0] fd(input bit mx);
    return mx ? b_out.data : a_out.data;
  endfunction
  function automatic logic fl(input bit mx);
    return mx ? b_out.last : a_out.last;
  endfunction
  function automatic logic fr(input bit mx);
    return mx ? b_in.ready : a_in.ready;
  endfunction
  function automatic logic fdn(input bit mx);
    return mx ? dn_b : dn_a;
  endfunction
  function automatic logic [CW-1:0] fc(input bit mx);
    return mx ? cnt_b : cnt_a;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] word);
    a_in.valid = 1'b1;
    a_in.data = word;
    step();
    a_in.valid = 1'b0;
    ea += int'(ev_a);
    eb += int'(ev_b);
  endtask
  task automatic do_init(input logic [CW-1:0] k);
    init = 1'b1;
    k_cfg = k;
    step();
    init = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask
  task automatic drain(input bit mx, input bit bp);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (bp) begin
        a_out.ready = 1'b0;
        chk("hold_valid", fv(mx), 1);
        chk("hold_data", fd(mx), exp_q[i]);
        step();
        chk("hold_data_stable", fd(mx), exp_q[i]);
        chk("hold_in_ready", fr(mx), 0);
      end
      a_out.ready = 1'b1;
      chk("out_valid", fv(mx), 1);
      chk("out_data", fd(mx), exp_q[i]);
      chk("out_last", fl(mx), (i == n - 1));
      chk("drain_in_ready", fr(mx), 0);
      chk("drain_done", fdn(mx), 0);
      step();
    end
    chk("done", fdn(mx), 1);
    chk("post_valid", fv(mx), 0);
    chk("post_in_ready", fr(mx), 1);
    chk("post_count", fc(mx), 0);
    step();
    chk("done_pulse", fdn(mx), 0);
    exp_q.delete();
  endtask
  initial begin
    a_in.valid = 1'b0;
    a_in.data = '0;
    a_in.last = 1'b0;
    a_out.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in.ready, 0);
    chk("rst_out_valid", a_out.valid, 0);
    chk("rst_out_data", a_out.data, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_done", dn_a, 0);
    chk("rst_evict", ev_a, 0);
    rstn = 1'b1;
    step();
    chk("rel_in_ready", a_in.ready, 1);
    push(w(1, 9)); push(w(2, 3)); push(w(3, 7)); push(w(4, 1));
    chk("min_evict_none", ea, 0);
    push(w(5, 8));
    chk("min_evict_pulse", ev_a, 1);
    push(w(6, 2));
    step();
    chk("min_evict_low", ev_a, 0);
    chk("min_evicts", ea, 2);
    chk("min_count", cnt_a, 4);
    do_flush();
    exp_q = '{w(4, 1), w(6, 2), w(2, 3), w(3, 7)};
    drain(0, 0);
    do_init(3'd3);
    eb = 0;
    push(w(1, 5)); push(w(2, 12)); push(w(3, 12)); push(w(4, 4)); push(w(5, 20));
    chk("max_evicts", eb, 2);
    chk("max_count", cnt_b, 3);
    do_flush();
    exp_q = '{w(5, 20), w(2, 12), w(3, 12)};
    drain(1, 0);
    do_init(3'd0);
    push(w(1, 30)); push(w(2, 10)); push(w(3, 20));
    a_out.ready = 1'b0;
    do_flush();
    exp_q = '{w(2, 10), w(3, 20), w(1, 30)};
    drain(0, 1);
    do_init(3'd0);
    push(w(1, 2)); push(w(2, 6));
    a_in.valid = 1'b1;
    a_in.data = w(9, 4);
    flush = 1'b1;
    step();
    a_in.valid = 1'b0;
    flush = 1'b0;
    exp_q = '{w(1, 2), w(9, 4), w(2, 6)};
    drain(0, 0);
    do_flush();
    chk("empty_done", dn_a, 1);
    chk("empty_valid", a_out.valid, 0);
    chk("empty_in_ready", a_in.ready, 1);
    step();
    chk("empty_done_pulse", dn_a, 0);
    chk("empty_valid2", a_out.valid, 0);
    do_init(3'd0);
    push(w(1, 5)); push(w(2, 1)); push(w(3, 3));
    do_flush();
    chk("abort_first", a_out.data, w(2, 1));
    step();
    chk("abort_second", a_out.data, w(3, 3));
    init = 1'b1;
    step();
    init = 1'b0;
    chk("abort_valid", a_out.valid, 0);
    chk("abort_count", cnt_a, 0);
    chk("abort_done", dn_a, 0);
    chk("abort_in_ready", a_in.ready, 1);
    step();
    chk("abort_no_done", dn_a, 0);
    push(w(1, 8)); push(w(2, 6));
    do_flush();
    exp_q = '{w(2, 6), w(1, 8)};
    drain(0, 0);
    push(w(1, 1));
    a_in.valid = 1'b1;
    a_in.data = w(2, 2);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_in_ready", a_in.ready, 0);
    chk("arst_valid", a_out.valid, 0);
    chk("arst_count", cnt_a, 0);
    chk("arst_evict", ev_a, 0);
    chk("arst_done", dn_a, 0);
    a_in.valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("arel_in_ready", a_in.ready, 1);
    chk("arel_count", cnt_a, 0);
    push(w(7, 4));
    do_flush();
    exp_q = '{w(7, 4)};
    drain(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
